// File: rtl/uart_tx_frame_pkg.sv
// Shared definitions for the UART transmit path: FSM state encodings,
// default frame geometry and fixed line levels.
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int   UART_SIZE_DEF      = 32;
  localparam int   UART_MAX_RETRY_DEF = 3;

  // Line levels; parity is even (parity bit = XOR of all data bits).
  localparam logic UART_LINE_IDLE = 1'b1;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_piso.sv
// Parallel-in serial-out register. Loads a whole word, then shifts right so
// the next bit to transmit is always presented on bit_o (LSB first).
module uart_tx_piso #(
  parameter int SIZE = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            shift_i,
  input  logic [SIZE-1:0] data_i,
  output logic            bit_o
);

  logic [SIZE-1:0] shreg_q;

  // Load has priority over shift; zeros fill from the top.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
    end else if (shift_i) begin
      shreg_q <= {1'b0, shreg_q[SIZE-1:1]};
    end
  end

  assign bit_o = shreg_q[0];

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start(0), SIZE data bits LSB first, even parity,
// stop(1). Resends the held word when the receiver flags an error, up to
// MAX_RETRY times, then reports TxError.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  ST_IDLE   | line high, ReadyTx=1, waiting for StartTx
//  ST_START  | start bit (0) on the line
//  ST_DATA   | data bit bit_cnt on the line, 0..SIZE-1
//  ST_PARITY | even-parity bit on the line
//  ST_STOP   | stop bit (1); decide done / retry / abandon
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int SIZE      = UART_SIZE_DEF,
  parameter int MAX_RETRY = UART_MAX_RETRY_DEF
) (
  input  logic            CLK_Baudin,
  input  logic            RstTx,
  input  logic [SIZE-1:0] DataIn,
  input  logic            StartTx,
  output logic            ReadyTx,
  output logic            SerialOutputData,
  input  logic            Flag_Rx,
  output logic            DoneTx,
  output logic            TxError
);

  localparam int CNT_W = $clog2(SIZE);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  tx_state_e        state_q, state_d;
  logic [SIZE-1:0]  data_q, data_d;
  logic             par_q, par_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [RTY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic             resend_q, resend_d;
  logic             line_q, line_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             piso_load;
  logic             piso_shift;
  logic [SIZE-1:0]  piso_data;
  logic             piso_bit;

  // The shift register is reloaded on every entry to START, so a retry
  // replays the held word from data_q rather than the live DataIn.
  uart_tx_piso #(
    .SIZE (SIZE)
  ) u_piso (
    .clk_i   (CLK_Baudin),
    .rst_i   (RstTx),
    .load_i  (piso_load),
    .shift_i (piso_shift),
    .data_i  (piso_data),
    .bit_o   (piso_bit)
  );

  // Next-state, counters and next line value. The line is registered from
  // the state being entered, so the start bit appears the cycle after accept.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    retry_cnt_d = retry_cnt_q;
    resend_d    = resend_q;
    line_d      = UART_LINE_IDLE;
    done_d      = 1'b0;
    err_d       = 1'b0;
    piso_load   = 1'b0;
    piso_shift  = 1'b0;
    piso_data   = data_q;

    case (state_q)
      ST_IDLE: begin
        if (StartTx && ready_q) begin
          data_d      = DataIn;
          par_d       = ^DataIn;
          retry_cnt_d = '0;
          resend_d    = 1'b0;
          piso_load   = 1'b1;
          piso_data   = DataIn;
          line_d      = UART_START_BIT;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        resend_d   = resend_q | Flag_Rx;
        bit_cnt_d  = '0;
        line_d     = piso_bit;
        piso_shift = 1'b1;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        resend_d = resend_q | Flag_Rx;
        if (bit_cnt_q == CNT_W'(SIZE - 1)) begin
          line_d  = par_q;
          state_d = ST_PARITY;
        end else begin
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          line_d     = piso_bit;
          piso_shift = 1'b1;
        end
      end
      ST_PARITY: begin
        resend_d = resend_q | Flag_Rx;
        line_d   = UART_STOP_BIT;
        state_d  = ST_STOP;
      end
      ST_STOP: begin
        resend_d = 1'b0;
        if ((resend_q | Flag_Rx) && (retry_cnt_q < RTY_W'(MAX_RETRY))) begin
          retry_cnt_d = retry_cnt_q + RTY_W'(1);
          piso_load   = 1'b1;
          line_d      = UART_START_BIT;
          state_d     = ST_START;
        end else begin
          done_d  = 1'b1;
          err_d   = resend_q | Flag_Rx;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge CLK_Baudin) begin
    if (RstTx) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      par_q       <= 1'b0;
      bit_cnt_q   <= '0;
      retry_cnt_q <= '0;
      resend_q    <= 1'b0;
      line_q      <= UART_LINE_IDLE;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      resend_q    <= resend_d;
      line_q      <= line_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign SerialOutputData = line_q;
  assign ReadyTx          = ready_q;
  assign DoneTx           = done_q;
  assign TxError          = err_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: stimulus pushes expected frames and
// DoneTx events; a negedge monitor decodes the serial line and compares.
module tb_uart_tx_frame;

  localparam int SIZE = 32;

  logic            clk;
  logic            RstTx;
  logic [SIZE-1:0] DataIn;
  logic            StartTx;
  logic            ReadyTx;
  logic            SerialOutputData;
  logic            Flag_Rx;
  logic            DoneTx;
  logic            TxError;

  uart_tx_frame #(.SIZE(SIZE), .MAX_RETRY(3)) dut (
    .CLK_Baudin       (clk),
    .RstTx            (RstTx),
    .DataIn           (DataIn),
    .StartTx          (StartTx),
    .ReadyTx          (ReadyTx),
    .SerialOutputData (SerialOutputData),
    .Flag_Rx          (Flag_Rx),
    .DoneTx           (DoneTx),
    .TxError          (TxError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc_n is the index of the cycle that follows the latest posedge.
  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  typedef struct {
    logic [SIZE-1:0] data;
    logic            par;
    int              start_cyc;
  } frame_t;

  typedef struct {
    logic err;
    int   cyc;
  } done_t;

  frame_t exp_frames[$];
  done_t  exp_done[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic push_frame(input logic [SIZE-1:0] d, input logic p, input int sc);
    frame_t f;
    f.data = d; f.par = p; f.start_cyc = sc;
    exp_frames.push_back(f);
  endtask

  task automatic push_done(input logic e, input int c);
    done_t d;
    d.err = e; d.cyc = c;
    exp_done.push_back(d);
  endtask

  // ---------------- monitor ----------------
  int              rx_pos = 0;
  logic [SIZE-1:0] rx_data;
  logic            rx_par;
  int              rx_start;

  always @(negedge clk) begin
    frame_t f;
    done_t  d;
    if (RstTx) begin
      rx_pos = 0;
    end else if (rx_pos == 0) begin
      if (SerialOutputData == 1'b0) begin
        rx_pos   = 1;
        rx_start = cyc_n;
        rx_data  = '0;
      end
    end else if (rx_pos <= SIZE) begin
      rx_data[rx_pos-1] = SerialOutputData;
      rx_pos++;
    end else if (rx_pos == SIZE + 1) begin
      rx_par = SerialOutputData;
      rx_pos++;
    end else begin
      rx_pos = 0;
      if (exp_frames.size() == 0) begin
        tests++; fails++;
        $display("FAIL frame_unexpected: got data %h, none expected", rx_data);
      end else begin
        f = exp_frames.pop_front();
        check("frame_data", rx_data, f.data);
        check("frame_parity", rx_par, f.par);
        check("frame_stop", SerialOutputData, 1);
        check("frame_start_cycle", rx_start, f.start_cyc);
      end
    end

    if (DoneTx) begin
      if (exp_done.size() == 0) begin
        tests++; fails++;
        $display("FAIL done_unexpected: got DoneTx=1 at cycle %0d, none expected", cyc_n);
      end else begin
        d = exp_done.pop_front();
        check("done_err", TxError, d.err);
        check("done_cycle", cyc_n, d.cyc);
        check("ready_on_done", ReadyTx, 1);
      end
    end else if (TxError) begin
      tests++; fails++;
      $display("FAIL txerror_without_done: got TxError=1 DoneTx=0 at cycle %0d", cyc_n);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents a word for one cycle; acc is the accept cycle, so the start
  // bit is expected in acc+1 and DoneTx (clean) in acc+36.
  task automatic start_word(input logic [SIZE-1:0] d, output int acc);
    DataIn  = d;
    StartTx = 1'b1;
    acc     = cyc_n;
    tick();
    StartTx = 1'b0;
    DataIn  = ~d;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (exp_done.size() != 0 || exp_frames.size() != 0 || rx_pos != 0); i++)
      tick();
    tick();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && !DoneTx; i++)
      tick();
  endtask

  initial begin
    int acc;
    int acc2;
    logic [SIZE-1:0] w;

    RstTx = 1'b1; StartTx = 1'b0; Flag_Rx = 1'b0; DataIn = '0;
    tick();
    tick();
    check("rst_line", SerialOutputData, 1);
    check("rst_ready", ReadyTx, 1);
    check("rst_done", DoneTx, 0);
    check("rst_txerror", TxError, 0);
    RstTx = 1'b0;
    tick();

    // 1: single bit set -> parity 1
    start_word(32'h0000_0001, acc);
    push_frame(32'h0000_0001, 1'b1, acc + 1);
    push_done(1'b0, acc + 36);
    wait_idle();

    // 2: back-to-back on the DoneTx cycle, 16 ones -> parity 0
    start_word(32'hA5A5_A5A5, acc);
    push_frame(32'hA5A5_A5A5, 1'b0, acc + 1);
    push_done(1'b0, acc + 36);
    wait_done();
    check("b2b_ready", ReadyTx, 1);
    start_word(32'hA5A5_A5A5, acc2);
    push_frame(32'hA5A5_A5A5, 1'b0, acc + 37);
    push_done(1'b0, acc + 72);
    wait_idle();

    // 3: one Flag_Rx pulse during DATA -> one resend, clean finish
    start_word(32'h1234_5678, acc);
    push_frame(32'h1234_5678, 1'b1, acc + 1);
    push_frame(32'h1234_5678, 1'b1, acc + 36);
    push_done(1'b0, acc + 71);
    while (cyc_n < acc + 10) tick();
    Flag_Rx = 1'b1;
    tick();
    Flag_Rx = 1'b0;
    wait_idle();

    // 4: Flag_Rx in every frame -> 4 frames then TxError
    start_word(32'hFFFF_0000, acc);
    Flag_Rx = 1'b1;
    for (int k = 0; k < 4; k++) push_frame(32'hFFFF_0000, 1'b0, acc + 1 + 35 * k);
    push_done(1'b1, acc + 141);
    wait_done();
    Flag_Rx = 1'b0;
    wait_idle();

    // 5: reset mid-DATA drops the frame, then a clean frame
    start_word(32'h0F0F_0F0F, acc);
    while (cyc_n < acc + 10) tick();
    RstTx = 1'b1;
    tick();
    check("midrst_line", SerialOutputData, 1);
    check("midrst_ready", ReadyTx, 1);
    check("midrst_done", DoneTx, 0);
    tick();
    RstTx = 1'b0;
    tick();
    start_word(32'h8000_0000, acc);
    push_frame(32'h8000_0000, 1'b1, acc + 1);
    push_done(1'b0, acc + 36);
    wait_idle();

    // 6: Flag_Rx in IDLE ignored; StartTx held while busy ignored
    Flag_Rx = 1'b1;
    tick();
    tick();
    Flag_Rx = 1'b0;
    start_word(32'hDEAD_BEEF, acc);
    push_frame(32'hDEAD_BEEF, 1'b0, acc + 1);
    push_done(1'b0, acc + 36);
    StartTx = 1'b1;
    while (cyc_n < acc + 30) begin
      DataIn = DataIn + 32'h0101_0101;
      tick();
    end
    StartTx = 1'b0;
    wait_idle();

    // Random words through the line decoder
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      start_word(w, acc);
      push_frame(w, 1'($countones(w) % 2), acc + 1);
      push_done(1'b0, acc + 36);
      wait_idle();
    end

    check("drain_frames", exp_frames.size(), 0);
    check("drain_done", exp_done.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
